score_argmax_seq: RTL and testbench
===================================

SCORE_ARGMAX_SEQ -- requirements
Module: score_argmax_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning signed score width and internal sum width.
REQ-002 SHALL have parameter BIAS_WIDTH, default 16, meaning signed bias width; BIAS_WIDTH <= DATA_WIDTH.
REQ-003 SHALL have parameter NUM_CLASSES, default 10, meaning number of scores compared; legal range 1..16.
REQ-004 SHALL have parameter IDX_WIDTH, default 4, meaning class index width; 2**IDX_WIDTH >= NUM_CLASSES.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  single-cycle request to begin a classification.
REQ-009 scores  input  [NUM_CLASSES][DATA_WIDTH] signed  raw accumulator outputs from the systolic fetcher.
REQ-010 bias  input  [NUM_CLASSES][BIAS_WIDTH] signed  per-class bias.
REQ-011 busy  output  1  high while a scan is in progress.
REQ-012 ready  output  1  high while valid results are held.
REQ-013 class_idx  output  IDX_WIDTH  index of the winning class.
REQ-014 classes  output  NUM_CLASSES  one-hot winning class; bit class_idx set.
REQ-015 max_score  output  DATA_WIDTH signed  biased score of the winning class.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-017 In IDLE or DONE, start sampled high at edge E0 SHALL capture sum[i] = scores[i] + sign-extended bias[i] into an internal buffer, modulo 2**DATA_WIDTH with wrap-around and no saturation.
REQ-018 At E0 SHALL also set best_val = sum[0], best_idx = 0 and cnt = 1, deassert ready and enter SCAN.
REQ-019 In SCAN, each edge SHALL compare buffer[cnt] with best_val and replace best_val and best_idx only when strictly greater (signed); cnt SHALL then increment.
REQ-020 Ties SHALL resolve to the lowest index.
REQ-021 After the compare at cnt = NUM_CLASSES-1, the FSM SHALL enter DONE.
REQ-022 On the DONE-entry edge, class_idx, classes and max_score SHALL update and ready SHALL assert, exactly NUM_CLASSES edges after E0 (edge E0+NUM_CLASSES).
REQ-023 With NUM_CLASSES = 1, ready SHALL assert at E0+1 with class_idx = 0.
REQ-024 busy SHALL be high exactly in SCAN.
REQ-025 busy and ready SHALL never be high together.
REQ-026 start during SCAN SHALL be ignored, with no restart and no queuing.
REQ-027 Results and ready SHALL hold in DONE until the next accepted start.
REQ-028 Changes on scores or bias after E0 SHALL NOT affect the current result.

Reset
REQ-029 While reset is high, FSM SHALL be IDLE; busy, ready, class_idx, classes, max_score, cnt, best_val and best_idx SHALL be 0.
REQ-030 Reset asserted mid-SCAN SHALL abort immediately with no result produced.
REQ-031 The first start after reset deassertion SHALL be accepted normally.

Structure
REQ-032 A shared package sys_array_pkg SHALL hold the FSM state enum, default DATA_WIDTH/BIAS_WIDTH/NUM_CLASSES and the clog2-based IDX_WIDTH helper.
REQ-033 Sub-module argmax_cmp (combinational signed strict-greater compare-and-select of value/index pairs) SHALL be instantiated once.
REQ-034 The result feeds seg7_tohex_mnist through classes unchanged.

Verification
REQ-035 scores = {5,-3,100,7,0,0,0,0,0,-100}, bias all 0, start pulse -> ready at E0+10, class_idx = 2, classes = 10'b0000000100, max_score = 100.
REQ-036 scores all 0, bias = {0,0,0,0,0,0,0,0,4,4} -> class_idx = 8 (lowest-index tie), max_score = 4.
REQ-037 scores[3] = 32'h7FFFFFFF, bias[3] = 1, others -1 -> wrap: sum[3] = 32'h80000000, class_idx = 0, max_score = -1.
REQ-038 start re-pulsed at E0+4 with new scores -> ignored; result from the E0 data; busy held E0+1..E0+9.
REQ-039 reset asserted at E0+5 -> busy/ready = 0 at once, outputs 0; next start -> correct result at its own E0+10.
REQ-040 start in DONE with scores[9] maximal -> ready low after the start edge, busy high, ready back at +10 with class_idx = 9.

Source files
------------

// File: rtl/sys_array_pkg.sv
// Shared types and defaults for the systolic classifier back end.
// Holds the argmax FSM state encoding and index-width helper.
package sys_array_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_BIAS_WIDTH  = 16;
  localparam int DEF_NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Signed strict-greater compare-and-select of a value/index pair.
// Ties keep the current pair, so the lowest index wins.
module argmax_cmp #(
  parameter int W  = 32,
  parameter int IW = 4
) (
  input  logic signed [W-1:0]  cur_val,
  input  logic        [IW-1:0] cur_idx,
  input  logic signed [W-1:0]  cand_val,
  input  logic        [IW-1:0] cand_idx,
  output logic signed [W-1:0]  sel_val,
  output logic        [IW-1:0] sel_idx
);

  logic take;

  assign take    = cand_val > cur_val;
  assign sel_val = take ? cand_val : cur_val;
  assign sel_idx = take ? cand_idx : cur_idx;

endmodule

// File: rtl/score_argmax_seq.sv
// Sequential argmax over biased class scores.
// Captures sums on start, scans one class per cycle, holds result.
module score_argmax_seq
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BIAS_WIDTH  = DEF_BIAS_WIDTH,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int IDX_WIDTH   = idx_width(NUM_CLASSES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] scores [NUM_CLASSES],
  input  logic signed [BIAS_WIDTH-1:0] bias   [NUM_CLASSES],
  output logic                         busy,
  output logic                         ready,
  output logic        [IDX_WIDTH-1:0]  class_idx,
  output logic        [NUM_CLASSES-1:0] classes,
  output logic signed [DATA_WIDTH-1:0] max_score
);

  localparam int CW = $clog2(NUM_CLASSES + 1);

  argmax_state_e state;
  logic [CW-1:0] cnt;
  logic signed [DATA_WIDTH-1:0] best_val;
  logic [IDX_WIDTH-1:0] best_idx;

  logic signed [DATA_WIDTH-1:0] sum   [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] buf_q [NUM_CLASSES];

  logic signed [DATA_WIDTH-1:0] cand_val;
  logic [IDX_WIDTH-1:0] cand_idx;
  logic signed [DATA_WIDTH-1:0] sel_val;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic accept;

  // Wrap-around add; the cast sign-extends the signed bias.
  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      sum[i] = scores[i] + DATA_WIDTH'(bias[i]);
    end
  end

  always_comb begin
    cand_val = '0;
    cand_idx = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (cnt == CW'(i)) begin
        cand_val = buf_q[i];
        cand_idx = IDX_WIDTH'(i);
      end
    end
  end

  argmax_cmp #(
    .W  (DATA_WIDTH),
    .IW (IDX_WIDTH)
  ) u_cmp (
    .cur_val  (best_val),
    .cur_idx  (best_idx),
    .cand_val (cand_val),
    .cand_idx (cand_idx),
    .sel_val  (sel_val),
    .sel_idx  (sel_idx)
  );

  assign accept = start && (state != SCAN);
  assign busy   = state == SCAN;
  assign ready  = state == DONE;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        buf_q[i] <= sum[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      class_idx <= '0;
      classes   <= '0;
      max_score <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= SCAN;
            cnt      <= CW'(1);
            best_val <= sum[0];
            best_idx <= '0;
          end
        end
        SCAN: begin
          // cnt == NUM_CLASSES means every class has been compared
          if (cnt == CW'(NUM_CLASSES)) begin
            state     <= DONE;
            class_idx <= best_idx;
            max_score <= best_val;
            classes   <= NUM_CLASSES'(1) << best_idx;
          end else begin
            best_val <= sel_val;
            best_idx <= sel_idx;
            cnt      <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_argmax_seq.sv
// Directed bench for score_argmax_seq: vector table plus
// hand-written restart, reset-abort and hold sequences.
module tb_score_argmax_seq;

  localparam int NC = 10;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic signed [31:0] scores [NC];
  logic signed [15:0] bias   [NC];
  logic busy, ready;
  logic [3:0] class_idx;
  logic [NC-1:0] classes;
  logic signed [31:0] max_score;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [31:0] s [NC];
    logic signed [15:0] b [NC];
    int                 idx;
    logic signed [31:0] mx;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  score_argmax_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .scores    (scores),
    .bias      (bias),
    .busy      (busy),
    .ready     (ready),
    .class_idx (class_idx),
    .classes   (classes),
    .max_score (max_score)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input int v);
    scores = vecs[v].s;
    bias   = vecs[v].b;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called just after E0; walks to E0+10 and checks the result.
  // A nonzero repulse_at re-pulses start with vector 5 at that edge.
  task automatic expect_done(input string nm, input int idx,
                             input logic signed [31:0] mx,
                             input int repulse_at);
    logic bad;
    bad = (busy !== 1'b1) || (ready !== 1'b0);
    for (int k = 1; k < NC; k++) begin
      if (k == repulse_at) begin
        @(negedge clk);
        start = 1'b1;
        apply(5);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if ((busy !== 1'b1) || (ready !== 1'b0)) bad = 1'b1;
    end
    chk({nm, "_scan"}, 64'(bad), 64'(0));
    @(posedge clk);
    #1;
    chk({nm, "_ready"}, {62'd0, busy, ready}, 64'd1);
    chk({nm, "_idx"}, 64'(class_idx), 64'(idx));
    chk({nm, "_onehot"}, 64'(classes), 64'(NC'(1) << idx));
    chk({nm, "_max"}, 64'(max_score), 64'(mx));
  endtask

  initial begin
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NC; i++) begin
        vecs[v].s[i] = '0;
        vecs[v].b[i] = '0;
      end
    end
    vecs[0].s[0] = 5;   vecs[0].s[1] = -3;
    vecs[0].s[2] = 100; vecs[0].s[3] = 7;
    vecs[0].s[9] = -100;
    vecs[0].idx = 2; vecs[0].mx = 100;

    vecs[1].b[8] = 4; vecs[1].b[9] = 4;
    vecs[1].idx = 8; vecs[1].mx = 4;

    for (int i = 0; i < NC; i++) vecs[2].s[i] = -1;
    vecs[2].s[3] = 32'h7FFF_FFFF; vecs[2].b[3] = 1;
    vecs[2].idx = 0; vecs[2].mx = -1;

    for (int i = 0; i < NC; i++) vecs[3].s[i] = -50;
    vecs[3].idx = 0; vecs[3].mx = -50;

    for (int i = 0; i < NC; i++) begin
      vecs[4].s[i] = 10 * i;
      vecs[4].b[i] = 16'(-10 * i);
    end
    vecs[4].b[6] = -59;
    vecs[4].idx = 6; vecs[4].mx = 1;

    for (int i = 0; i < NC; i++) vecs[5].s[i] = i;
    vecs[5].s[9] = 1000;
    vecs[5].idx = 9; vecs[5].mx = 1000;

    reset = 1'b1;
    start = 1'b0;
    apply(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {62'd0, busy, ready}, 64'd0);
    chk("rst_idx", 64'(class_idx), 64'd0);
    chk("rst_onehot", 64'(classes), 64'd0);
    chk("rst_max", 64'(max_score), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      apply(v);
      pulse_start();
      expect_done($sformatf("vec%0d", v), vecs[v].idx, vecs[v].mx, 0);
    end

    // Held in DONE while inputs change underneath.
    apply(1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_ready", 64'(ready), 64'd1);
    chk("hold_idx", 64'(class_idx), 64'd9);
    chk("hold_max", 64'(max_score), 64'd1000);

    // Restart attempt at E0+4 with new data is ignored.
    apply(0);
    pulse_start();
    expect_done("repulse", 2, 100, 4);

    // Reset mid-scan aborts at once.
    apply(0);
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_flags", {62'd0, busy, ready}, 64'd0);
    chk("abort_idx", 64'(class_idx), 64'd0);
    chk("abort_max", 64'(max_score), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    apply(5);
    pulse_start();
    expect_done("after_rst", 9, 1000, 0);

    // Start accepted from DONE.
    apply(0);
    pulse_start();
    expect_done("pre_done", 2, 100, 0);
    apply(5);
    pulse_start();
    chk("redo_flags", {62'd0, busy, ready}, 64'd2);
    expect_done("from_done", 9, 1000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
